// File: rtl/alu_pipe_cc.sv
// Single-stage Y86 execute ALU (ADD/SUB/AND/XOR) with a registered output,
// valid/ready handshakes, an architectural condition-code register and a completed-op counter.
module alu_pipe_cc #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_fun,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_e,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic [CNT_W-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    FUN_ADD = 4'd0,
    FUN_SUB = 4'd1,
    FUN_AND = 4'd2,
    FUN_XOR = 4'd3
  } fun_e;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] res_e;
  logic             res_zf;
  logic             res_sf;
  logic             res_of;
  logic             res_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = out_valid && out_ready;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    res_e   = '0;
    res_of  = 1'b0;
    res_err = 1'b0;
    case (in_fun)
      FUN_ADD: begin
        res_e  = in_b + in_a;
        res_of = (in_a[MSB] == in_b[MSB]) && (res_e[MSB] != in_a[MSB]);
      end
      FUN_SUB: begin
        res_e  = in_b - in_a;
        res_of = (in_a[MSB] != in_b[MSB]) && (res_e[MSB] != in_b[MSB]);
      end
      FUN_AND: res_e = in_a & in_b;
      FUN_XOR: res_e = in_a ^ in_b;
      default: res_err = 1'b1;
    endcase
    res_zf = (res_e == '0);
    res_sf = res_e[MSB];
  end

  // Result register: reload on accept (even when completing the same cycle), else drain.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_e     <= '0;
      out_zf    <= 1'b0;
      out_sf    <= 1'b0;
      out_of    <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_e     <= res_e;
      out_zf    <= res_zf;
      out_sf    <= res_sf;
      out_of    <= res_of;
      out_err   <= res_err;
    end else if (complete) begin
      out_valid <= 1'b0;
    end
  end

  // CC tracks accepted ops immediately, independent of output backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (accept && in_set_cc && !res_err) begin
      cc_zf <= res_zf;
      cc_sf <= res_sf;
      cc_of <= res_of;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (complete) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Scoreboard bench for alu_pipe_cc: randomized ops against a signed-arithmetic reference model,
// plus a narrow (WIDTH=8, CNT_W=2) instance for overflow and counter wrap.
module tb_alu_pipe_cc;

  typedef struct packed {
    logic [63:0] e;
    logic        zf;
    logic        sf;
    logic        ovf;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_set_cc;
  logic [3:0]  in_fun;
  logic [63:0] in_a, in_b, out_e;
  logic        out_valid, out_ready;
  logic        out_zf, out_sf, out_of, out_err, cc_zf, cc_sf, cc_of;
  logic [31:0] op_count;

  logic        v8, r8, sc8, rdy8, ov8, zf8, sf8, of8, err8, cczf8, ccsf8, ccof8;
  logic [3:0]  f8;
  logic [7:0]  a8, b8, e8;
  logic [1:0]  cnt8;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        q[$];
  logic        m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic [31:0] m_count = '0;
  logic        force_ready = 1'b1;
  logic        ready_val = 1'b1;

  alu_pipe_cc #(.WIDTH(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fun(in_fun),
    .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc), .out_valid(out_valid),
    .out_ready(out_ready), .out_e(out_e), .out_zf(out_zf), .out_sf(out_sf),
    .out_of(out_of), .out_err(out_err), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .op_count(op_count)
  );

  alu_pipe_cc #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_fun(f8),
    .in_a(a8), .in_b(b8), .in_set_cc(sc8), .out_valid(ov8),
    .out_ready(rdy8), .out_e(e8), .out_zf(zf8), .out_sf(sf8),
    .out_of(of8), .out_err(err8), .cc_zf(cczf8), .cc_sf(ccsf8), .cc_of(ccof8),
    .op_count(cnt8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference: widen to WIDTH+1 signed bits; overflow when the result does not fit back.
  function automatic exp_t model(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    exp_t r;
    logic signed [64:0] sa, sb, wide;
    r = '0;
    sa = {a[63], a};
    sb = {b[63], b};
    wide = '0;
    case (f)
      4'd0: begin wide = sb + sa; r.e = wide[63:0]; r.ovf = wide[64] ^ wide[63]; end
      4'd1: begin wide = sb - sa; r.e = wide[63:0]; r.ovf = wide[64] ^ wide[63]; end
      4'd2: r.e = a & b;
      4'd3: r.e = a ^ b;
      default: r.err = 1'b1;
    endcase
    r.zf = (r.e == 64'd0);
    r.sf = r.e[63];
    return r;
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 15));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Present one op, wait for acceptance, record the expectation; returns 1 ns after the accept edge.
  task automatic issue(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b, input logic sc);
    exp_t x;
    int   waited;
    waited = 0;
    in_valid = 1'b1; in_fun = f; in_a = a; in_b = b; in_set_cc = sc;
    forever begin
      @(negedge clk); #1;
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        timeout("accept_wait");
        in_valid = 1'b0;
        return;
      end
    end
    x = model(f, a, b);
    q.push_back(x);
    if (sc && !x.err) begin
      m_zf = x.zf; m_sf = x.sf; m_of = x.ovf;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (q.size() != 0) begin
      @(posedge clk); #1;
      waited++;
      if (waited > 100) begin
        timeout("drain_wait");
        q.delete();
      end
    end
  endtask

  always begin
    @(posedge clk); #2;
    out_ready = force_ready ? ready_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares held/completing results, CC and counter against the model every cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst) continue;
      check("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        x = q[0];
        check("out_e", out_e, x.e);
        check("out_flags", {out_zf, out_sf, out_of, out_err}, {x.zf, x.sf, x.ovf, x.err});
        if (out_ready) void'(q.pop_front());
      end
      check("cc", {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
      check("op_count", op_count, m_count);
      if (out_valid && out_ready) m_count = m_count + 32'd1;
    end
  end

  initial begin
    logic [63:0] a, b;
    logic [3:0]  f;
    rst = 1'b1; in_valid = 1'b0; in_fun = '0; in_a = '0; in_b = '0; in_set_cc = 1'b0;
    out_ready = 1'b1;
    v8 = 1'b0; f8 = '0; a8 = '0; b8 = '0; sc8 = 1'b0; rdy8 = 1'b1;
    #2;
    check("rst_state", {out_valid, out_e, out_zf, out_sf, out_of, out_err},
          {1'b0, 64'd0, 4'b0000});
    check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("rst_count", op_count, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Directed ops from the plan, out_ready held high.
    issue(4'd3, 64'd69, -64'sd96, 1'b1);
    check("xor_e", out_e, 64'hFFFF_FFFF_FFFF_FFE5);
    check("xor_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
    issue(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    check("add_ovf", {out_e, out_zf, out_sf, out_of}, {64'h8000_0000_0000_0000, 3'b011});
    issue(4'd1, 64'd5, 64'd5, 1'b1);
    check("sub_zero", {out_e, out_zf, out_of}, {64'd0, 2'b10});
    issue(4'd2, 64'd14, 64'd9, 1'b0);
    check("and_e", out_e, 64'd8);
    issue(4'd7, 64'd4, 64'd5, 1'b1);
    check("illegal", {out_e, out_err, out_zf}, {64'd0, 2'b11});
    drain();

    // Backpressure: one op held for 5 cycles, second op blocked, then Complete+Accept together.
    ready_val = 1'b0;
    issue(4'd0, 64'd3, 64'd4, 1'b1);
    in_valid = 1'b1; in_fun = 4'd1; in_a = 64'd1; in_b = 64'd10; in_set_cc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_in_ready", in_ready, 1'b0);
    end
    ready_val = 1'b1;
    issue(4'd1, 64'd1, 64'd10, 1'b1);
    check("bp_no_bubble", out_valid, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    force_ready = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      a = rand_op();
      b = ($urandom_range(0, 7) == 0) ? a : rand_op();
      issue(f, a, b, 1'($urandom_range(0, 1)));
    end
    force_ready = 1'b1;
    ready_val = 1'b1;
    drain();

    // Reset mid-stream with a result held under backpressure.
    issue(4'd0, 64'd1, 64'd1, 1'b1);
    drain();
    ready_val = 1'b0;
    issue(4'd0, 64'd2, 64'd2, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("mid_rst_count", op_count, 64'd0);
    q.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_count = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    ready_val = 1'b1;
    issue(4'd1, 64'd7, 64'd3, 1'b1);
    check("post_rst_latency", {out_valid, out_e}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC});
    drain();

    // Narrow instance: 8-bit overflow and 2-bit counter wrap.
    v8 = 1'b1; f8 = 4'd0; a8 = 8'h7F; b8 = 8'h01; sc8 = 1'b1;
    @(posedge clk); #1;
    check("w8_add", {ov8, e8, zf8, sf8, of8}, {1'b1, 8'h80, 3'b011});
    check("w8_cc", {cczf8, ccsf8, ccof8}, 3'b011);
    a8 = 8'h10; b8 = 8'h20;
    repeat (3) @(posedge clk);
    #1;
    check("w8_count3", cnt8, 2'd3);
    v8 = 1'b0;
    @(posedge clk); #1;
    check("w8_wrap", cnt8, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
